// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned shift-and-subtract divider, one quotient bit per clock
// Results (q/r/dbz) are held between completions; a new start may be accepted in the DONE cycle.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dbz
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // A set carry-out bit means the shifted remainder already exceeds any divisor,
   // and the low WIDTH bits of the difference are then exact.
   always_comb begin
      shifted = {rem, dvd[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - dvs;
      ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs);
      rem_nxt = ge ? diff : shifted[WIDTH-1:0];
      quo_nxt = {dvd[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         dvd   <= '0;
         dvs   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         q     <= '0;
         r     <= '0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done  <= 1'b0;
               state <= IDLE;
               if (start) begin
                  dvs <= in2;
                  dvd <= in1;
                  rem <= '0;
                  cnt <= CW'(WIDTH);
                  if (in2 == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     q     <= '1;
                     r     <= in1;
                     dbz   <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               rem <= rem_nxt;
               dvd <= quo_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  q     <= quo_nxt;
                  r     <= rem_nxt;
                  dbz   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider with a result scoreboard
module tb_seq_divider;

   localparam int WIDTH = 32;
   localparam int CW    = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             dbz;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(WIDTH), .CW(CW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .r     (r),
      .dbz   (dbz)
   );

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      logic             edbz;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      logic             edbz;
      int               ecyc;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[12];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest accepted division.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("q", q, e.eq);
            check("r", r, e.er);
            check("dbz", dbz, e.edbz);
            check("latency_cycle", cyc, e.ecyc);
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(logic [WIDTH-1:0] eq, logic [WIDTH-1:0] er, logic edbz);
      exp_t e;
      e.eq   = eq;
      e.er   = er;
      e.edbz = edbz;
      e.ecyc = cyc + 1 + (edbz ? 0 : WIDTH);
      sb.push_back(e);
   endtask

   task automatic push_model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      if (b == '0) push('1, a, 1'b1);
      else         push(a / b, a % b, 1'b0);
   endtask

   task automatic do_start(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
      in1   = a;
      in2   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      in1   = $urandom;
      in2   = $urandom;
   endtask

   task automatic wait_all();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL completion_timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      tick();
   endtask

   initial begin
      tbl[0]  = '{32'd100,        32'd7,        32'd14,         32'd2,        1'b0};
      tbl[1]  = '{32'd29,         32'd33,       32'd0,          32'd29,       1'b0};
      tbl[2]  = '{32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,        1'b0};
      tbl[3]  = '{32'd56,         32'd56,       32'd1,          32'd0,        1'b0};
      tbl[4]  = '{32'd44,         32'd0,        32'hFFFF_FFFF,  32'd44,       1'b1};
      tbl[5]  = '{32'd0,          32'd5,        32'd0,          32'd0,        1'b0};
      tbl[6]  = '{32'd36,         32'd5,        32'd7,          32'd1,        1'b0};
      tbl[7]  = '{32'd33,         32'd4,        32'd8,          32'd1,        1'b0};
      tbl[8]  = '{32'd56,         32'd3,        32'd18,         32'd2,        1'b0};
      tbl[9]  = '{32'd1000000,    32'd999,      32'd1001,       32'd1,        1'b0};
      tbl[10] = '{32'hFFFF_FFFF,  32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
      tbl[11] = '{32'h8000_0000,  32'd3,        32'h2AAA_AAAA,  32'd2,        1'b0};

      rst   = 1'b1;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      tick(2);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_q", q, 0);
      check("reset_r", r, 0);
      check("reset_dbz", dbz, 0);
      rst = 1'b0;
      tick();

      // Basic division with timing of busy/done around completion.
      push(32'd14, 32'd2, 1'b0);
      do_start(32'd100, 32'd7);
      check("basic_busy_start", busy, 1);
      tick(WIDTH - 1);
      check("basic_busy_last", busy, 1);
      check("basic_done_early", done, 0);
      tick();
      check("basic_done", done, 1);
      check("basic_busy_end", busy, 0);
      tick();
      check("basic_done_low", done, 0);
      check("basic_q_held", q, 32'd14);
      check("basic_r_held", r, 32'd2);
      wait_all();

      for (int i = 0; i < 12; i++) begin
         push(tbl[i].eq, tbl[i].er, tbl[i].edbz);
         do_start(tbl[i].a, tbl[i].b);
         check("tbl_busy", busy, {31'b0, ~tbl[i].edbz});
         wait_all();
      end

      // Divide by zero: busy never rises, done the very next cycle.
      push('1, 32'd44, 1'b1);
      do_start(32'd44, 32'd0);
      check("dbz_busy", busy, 0);
      check("dbz_done", done, 1);
      tick();
      check("dbz_busy_after", busy, 0);
      check("dbz_done_low", done, 0);
      wait_all();

      // Start during RUN is ignored.
      push(32'd18, 32'd2, 1'b0);
      do_start(32'd56, 32'd3);
      tick(9);
      in1   = 32'd4;
      in2   = 32'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ignored_start_busy", busy, 1);
      wait_all();

      // Back-to-back acceptance in the DONE cycle.
      push(32'd7, 32'd1, 1'b0);
      do_start(32'd36, 32'd5);
      tick(WIDTH);
      check("b2b_done", done, 1);
      push(32'd8, 32'd1, 1'b0);
      in1   = 32'd33;
      in2   = 32'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_q_held", q, 32'd7);
      tick(10);
      check("b2b_q_held_mid", q, 32'd7);
      check("b2b_r_held_mid", r, 32'd1);
      wait_all();

      // Reset mid-division aborts it with no done pulse.
      push(32'd14, 32'd2, 1'b0);
      do_start(32'd100, 32'd7);
      tick(14);
      rst = 1'b1;
      sb.delete();
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_q", q, 0);
      check("abort_r", r, 0);
      check("abort_dbz", dbz, 0);
      tick(40);
      push(32'd14, 32'd2, 1'b0);
      do_start(32'd100, 32'd7);
      wait_all();

      for (int i = 0; i < 8; i++) begin
         logic [WIDTH-1:0] a;
         logic [WIDTH-1:0] b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         push_model(a, b);
         do_start(a, b);
         wait_all();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
